// File: rtl/bsg_demux_pkg.sv
// Shared defaults and helpers for the buffered 1-to-N demultiplexer.
package bsg_demux_pkg;

   localparam int unsigned def_width_p  = 8;
   localparam int unsigned def_els_p    = 8;
   localparam int unsigned def_lg_els_p = 3;

   // Total buffered words range 0..2*els, so the counter needs one extra bit.
   function automatic int unsigned count_width(input int unsigned els);
      return $clog2(2 * els + 1);
   endfunction

endpackage

// File: rtl/bsg_demux_buffered_width_p8_els_p8_if.sv
// Producer/consumer bundle for the buffered demux; clock and reset stay outside.
interface bsg_demux_buffered_width_p8_els_p8_if
   import bsg_demux_pkg::*;
  #(parameter int unsigned width_p   = def_width_p,
    parameter int unsigned els_p     = def_els_p,
    parameter int unsigned lg_els_lp = def_lg_els_p,
    parameter int unsigned count_w_p = count_width(def_els_p));

   logic                       v_i;
   logic [width_p-1:0]         data_i;
   logic [lg_els_lp-1:0]       sel_i;
   logic                       ready_o;
   logic [els_p-1:0]           v_o;
   logic [els_p*width_p-1:0]   data_o;
   logic [els_p-1:0]           yumi_i;
   logic [count_w_p-1:0]       count_o;

   modport master (output v_i, data_i, sel_i, yumi_i,
                   input  ready_o, v_o, data_o, count_o);

   modport slave  (input  v_i, data_i, sel_i, yumi_i,
                   output ready_o, v_o, data_o, count_o);

endinterface

// File: rtl/bsg_demux_chan_two_fifo.sv
// Two-entry FIFO for one demux channel: registered head, no enqueue bypass.
module bsg_demux_chan_two_fifo
   import bsg_demux_pkg::*;
  #(parameter int unsigned width_p = def_width_p)
  (input  logic               clk_i,
   input  logic               reset_i,
   input  logic               enq_i,
   input  logic [width_p-1:0] data_i,
   input  logic               deq_i,
   output logic               v_o,
   output logic               full_o,
   output logic [width_p-1:0] data_o);

   logic [1:0]         occ_q, occ_d;
   logic [width_p-1:0] head_q, head_d;
   logic [width_p-1:0] tail_q, tail_d;
   logic               push, pop;

   assign v_o    = (occ_q != 2'd0);
   assign full_o = (occ_q == 2'd2);
   assign data_o = v_o ? head_q : '0;

   // Next state; head always holds the oldest word.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      push   = enq_i & ~full_o;
      pop    = deq_i & v_o;
      case (occ_q)
         2'd0: begin
            if (push) begin
               head_d = data_i;
               occ_d  = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = data_i;
            end else if (push) begin
               tail_d = data_i;
               occ_d  = 2'd2;
            end else if (pop) begin
               occ_d  = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               head_d = tail_q;
               occ_d  = 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         occ_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(deq_i && !v_o))
            else $error("dequeue requested on empty channel");
      end
   end

endmodule

// File: rtl/bsg_demux_buffered_width_p8_els_p8.sv
// Buffered 1-to-els_p demux: sel decode, ready mux and occupancy counter over
// one two-entry FIFO per channel.
module bsg_demux_buffered_width_p8_els_p8
   import bsg_demux_pkg::*;
  #(parameter int unsigned width_p   = def_width_p,
    parameter int unsigned els_p     = def_els_p,
    parameter int unsigned lg_els_lp = def_lg_els_p)
  (input  logic clk_i,
   input  logic reset_i,
   bsg_demux_buffered_width_p8_els_p8_if.slave bus);

   localparam int unsigned count_w_lp = count_width(els_p);

   logic [els_p-1:0]              full;
   logic [els_p-1:0]              enq;
   logic [els_p-1:0]              chan_v;
   logic [els_p-1:0][width_p-1:0] chan_data;
   logic [count_w_lp-1:0]         count_q, count_d;

   assign bus.ready_o = ~full[bus.sel_i];
   assign bus.v_o     = chan_v;
   assign bus.data_o  = chan_data;
   assign bus.count_o = count_q;

   always_comb begin
      enq             = '0;
      enq[bus.sel_i]  = bus.v_i & bus.ready_o;
   end

   for (genvar k = 0; k < els_p; k++) begin : g_chan
      bsg_demux_chan_two_fifo #(.width_p(width_p)) u_chan
        (.clk_i  (clk_i),
         .reset_i(reset_i),
         .enq_i  (enq[k]),
         .data_i (bus.data_i),
         .deq_i  (bus.yumi_i[k]),
         .v_o    (chan_v[k]),
         .full_o (full[k]),
         .data_o (chan_data[k]));
   end

   // Only dequeues of non-empty channels are counted.
   always_comb begin
      count_d = count_q;
      for (int k = 0; k < els_p; k++) begin
         count_d = count_d + count_w_lp'(enq[k])
                           - count_w_lp'(bus.yumi_i[k] & chan_v[k]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) count_q <= '0;
      else         count_q <= count_d;
   end

endmodule

// File: tb/tb_bsg_demux_buffered_width_p8_els_p8.sv
// Directed, table-driven bench for the buffered 8-channel demux.
module tb_bsg_demux_buffered_width_p8_els_p8;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   bsg_demux_buffered_width_p8_els_p8_if #(.width_p(8), .els_p(8), .lg_els_lp(3), .count_w_p(5)) bus ();

   bsg_demux_buffered_width_p8_els_p8 dut
     (.clk_i  (clk),
      .reset_i(reset),
      .bus    (bus));

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic [2:0] sel;
      logic [7:0] yumi;
      logic       rdy;   // ready_o before the edge
      logic [7:0] ev;    // v_o after the edge
      logic [4:0] ecnt;  // count_o after the edge
      logic [2:0] ch;    // channel whose data is checked after the edge
      logic [7:0] ed;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] sel, input logic [7:0] yumi);
      bus.v_i    = v;
      bus.data_i = d;
      bus.sel_i  = sel;
      bus.yumi_i = yumi;
   endtask

   function automatic logic [7:0] chan_data(input int ch);
      return bus.data_o[ch*8 +: 8];
   endfunction

   initial begin
      vecs[0]  = '{1'b1, 8'hA5, 3'd5, 8'h00, 1'b1, 8'h20, 5'd1, 3'd5, 8'hA5};
      vecs[1]  = '{1'b0, 8'h00, 3'd5, 8'h20, 1'b1, 8'h00, 5'd0, 3'd5, 8'h00};
      vecs[2]  = '{1'b1, 8'h11, 3'd2, 8'h00, 1'b1, 8'h04, 5'd1, 3'd2, 8'h11};
      vecs[3]  = '{1'b1, 8'h22, 3'd2, 8'h00, 1'b1, 8'h04, 5'd2, 3'd2, 8'h11};
      vecs[4]  = '{1'b1, 8'h33, 3'd2, 8'h00, 1'b0, 8'h04, 5'd2, 3'd2, 8'h11};
      vecs[5]  = '{1'b1, 8'h44, 3'd2, 8'h04, 1'b0, 8'h04, 5'd1, 3'd2, 8'h22};
      vecs[6]  = '{1'b0, 8'h00, 3'd2, 8'h04, 1'b1, 8'h00, 5'd0, 3'd2, 8'h00};
      vecs[7]  = '{1'b1, 8'h5A, 3'd0, 8'h00, 1'b1, 8'h01, 5'd1, 3'd0, 8'h5A};
      vecs[8]  = '{1'b1, 8'h7E, 3'd0, 8'h01, 1'b1, 8'h01, 5'd1, 3'd0, 8'h7E};
      vecs[9]  = '{1'b1, 8'hC3, 3'd7, 8'h00, 1'b1, 8'h81, 5'd2, 3'd7, 8'hC3};
      vecs[10] = '{1'b1, 8'hD4, 3'd7, 8'h01, 1'b1, 8'h80, 5'd2, 3'd7, 8'hC3};
      vecs[11] = '{1'b0, 8'h00, 3'd7, 8'h80, 1'b0, 8'h80, 5'd1, 3'd7, 8'hD4};
      vecs[12] = '{1'b0, 8'h00, 3'd7, 8'h80, 1'b1, 8'h00, 5'd0, 3'd7, 8'h00};

      reset = 1'b1;
      drive(1'b0, 8'h00, 3'd0, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Idle after reset: everything empty, every channel ready.
      check("reset_v_o", 64'(bus.v_o), 64'h00);
      check("reset_count", 64'(bus.count_o), 64'd0);
      check("reset_data", bus.data_o, 64'h0);
      for (int s = 0; s < 8; s++) begin
         bus.sel_i = 3'(s);
         #1;
         check($sformatf("reset_ready_sel%0d", s), 64'(bus.ready_o), 64'd1);
      end

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].d, vecs[i].sel, vecs[i].yumi);
         #1;
         check($sformatf("vec%0d_ready", i), 64'(bus.ready_o), 64'(vecs[i].rdy));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_v_o", i), 64'(bus.v_o), 64'(vecs[i].ev));
         check($sformatf("vec%0d_count", i), 64'(bus.count_o), 64'(vecs[i].ecnt));
         check($sformatf("vec%0d_data", i), 64'(chan_data(int'(vecs[i].ch))), 64'(vecs[i].ed));
      end

      // Fill every channel with two words.
      for (int c = 0; c < 8; c++) begin
         for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            drive(1'b1, 8'(c * 16 + w), 3'(c), 8'h00);
            @(posedge clk);
         end
      end
      @(negedge clk);
      drive(1'b0, 8'h00, 3'd0, 8'h00);
      check("full_count", 64'(bus.count_o), 64'd16);
      check("full_v_o", 64'(bus.v_o), 64'hFF);
      for (int c = 0; c < 8; c++) begin
         bus.sel_i = 3'(c);
         #1;
         check($sformatf("full_ready_sel%0d", c), 64'(bus.ready_o), 64'd0);
         check($sformatf("full_head_ch%0d", c), 64'(chan_data(c)), 64'(c * 16));
      end

      // Reset with concurrent enqueue and dequeue: nothing survives.
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 8'h99, 3'd3, 8'h08);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b0, 8'h00, 3'd0, 8'h00);
      #1;
      check("rst_mid_v_o", 64'(bus.v_o), 64'h00);
      check("rst_mid_count", 64'(bus.count_o), 64'd0);
      check("rst_mid_data", bus.data_o, 64'h0);
      for (int s = 0; s < 8; s++) begin
         bus.sel_i = 3'(s);
         #1;
         check($sformatf("rst_mid_ready_sel%0d", s), 64'(bus.ready_o), 64'd1);
      end

      // One clean word after the mid-run reset.
      @(negedge clk);
      drive(1'b1, 8'h3C, 3'd6, 8'h00);
      @(posedge clk);
      #1;
      check("post_rst_v_o", 64'(bus.v_o), 64'h40);
      check("post_rst_data", 64'(chan_data(6)), 64'h3C);
      check("post_rst_count", 64'(bus.count_o), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
